svm_axis_sample_unpacker: RTL
=============================

Name: svm_axis_sample_unpacker

Overview:
- AXI-Stream slave front end of the SVM accelerator. It consumes 32-bit beats on the s_axis_* bus and unpacks each beat into two 16-bit fixed-point feature samples.
- Samples are presented one per handshake to the SVM datapath, which computes dot products against support vectors held in BRAM.
- It enforces the per-vector sample count programmed over AXI-Lite, flags stream-length mismatches, and re-aligns to the next vector on error.

Parameters:
- C_S_AXIS_TDATA_WIDTH, 32, stream beat width; fixed at 2*WIDTH.
- WIDTH, 16, sample width.
- FIFO_DEPTH, 4, beat FIFO depth; power of 2, at least 2.
- LEN_W, 16, width of the sample-count register.

Ports:
- s_axis_aclk  in  1  clock
- s_axis_aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  32  beat data; sample0=[15:0], sample1=[31:16]
- s_axis_tstrb  in  4  byte strobes
- s_axis_tlast  in  1  last beat of vector
- s_axis_tvalid  in  1  beat valid
- s_axis_tready  out  1  beat accept
- start  in  1  single-cycle pulse that arms one vector
- num_samples  in  LEN_W  expected samples per vector, sampled on start
- smp_data  out  WIDTH  sample to datapath
- smp_valid  out  1  sample valid
- smp_ready  in  1  datapath accept
- smp_last  out  1  final sample of vector, qualified by smp_valid
- busy  out  1  high in RUN or FLUSH
- done  out  1  single-cycle pulse at end of vector
- len_err  out  1  sticky length-mismatch flag; cleared by start

Behaviour:
- Reset (asynchronous, s_axis_aresetn=0):
  - state=IDLE; FIFO emptied; counters=0.
  - All outputs are 0: tready, smp_data, smp_valid, smp_last, busy, done, len_err.
  - Reset mid-vector aborts with no done pulse.
- FSM states: IDLE, RUN, FLUSH.
- IDLE:
  - On start with num_samples≠0: latch num_samples into exp_cnt, clear len_err, smp_cnt=0, move to RUN.
  - On start with num_samples=0: done pulses next cycle; stay in IDLE; len_err cleared.
- start outside IDLE is ignored.
- s_axis_tready = (state==RUN && !fifo_full) || state==FLUSH. A beat is accepted on tvalid&&tready.
- In RUN, each accepted beat is pushed as {tdata, hi_ok = (tstrb[3:2]==2'b11), tlast}.
- In FLUSH, accepted beats are dropped.
- FIFO timing:
  - Registered; a beat accepted in cycle N can first drive smp_valid in N+1.
  - Push and pop in the same cycle are legal when full; tready stays tied to !fifo_full, so there is no same-cycle full bypass.
- Unpacker:
  - Half-select bit sel starts at 0. smp_data = sel ? head[31:16] : head[15:0]; smp_valid = state==RUN && !fifo_empty.
  - On handshake with sel=0: if hi_ok, set sel=1; else pop.
  - On handshake with sel=1: pop and set sel=0.
  - smp_data, smp_valid and smp_last hold stable while smp_valid && !smp_ready.
- Counting:
  - smp_cnt increments on each sample handshake.
  - smp_last = (smp_cnt==exp_cnt-1) OR (current half is the final half of a tlast beat).
- End of vector, evaluated on the handshake where smp_last=1:
  - a) Count reached AND half is final half of tlast beat: clean end. done pulses the next cycle, state=IDLE, len_err unchanged.
  - b) Count reached but not end of tlast beat (stream long): len_err=1, FIFO flushed, sel=0.
    - If the tlast beat was already accepted: go to IDLE and pulse done.
    - Else: go to FLUSH.
  - c) tlast beat exhausted before count reached (stream short): len_err=1, done pulses, state=IDLE.
- FLUSH: discard beats until one with tlast is accepted, then IDLE and pulse done.
- Odd exp_cnt: the last beat carries tstrb=4'b0011. The high half is never emitted, so no error is raised.
- Strobes:
  - tstrb[1:0]≠2'b11 on the low half is still delivered as-is; only tstrb[3:2] is interpreted.
  - Any other partial strobe is treated as hi_ok=0.
- busy = (state≠IDLE). done is high for exactly one cycle.

Decomposition:
- Package svm_axis_pkg:
  - WIDTH, C_S_AXIS_TDATA_WIDTH, LEN_W.
  - typedef enum logic[1:0] {IDLE, RUN, FLUSH} unpk_state_e.
  - typedef struct packed {logic [31:0] data; logic hi_ok; logic last;} axis_beat_t.
- Sub-module svm_axis_beat_fifo:
  - Parameterized sync FIFO of axis_beat_t.
  - Ports: push, pop, flush, full, empty, head.
  - Same clock and asynchronous active-low reset.

Test Plan:
- start with num_samples=4; beats 0x0002_0001 and 0x0004_0003 (tlast on the second), tstrb=4'hF, smp_ready=1 → smp_data 1,2,3,4 on consecutive cycles starting one cycle after the first beat; smp_last on 4; done pulses once; len_err=0.
- num_samples=3; beats 0x0002_0001 and 0x0000_0003 (tlast, tstrb=4'b0011) → samples 1,2,3; smp_last on 3; len_err=0.
- num_samples=2; three beats with tlast on the third → 2 samples, smp_last on the second, len_err=1; state goes to FLUSH; remaining beats accepted and dropped; done pulses after tlast; busy deasserts.
- num_samples=6; two beats with tlast on the second → 4 samples, smp_last on the fourth, len_err=1, done pulses.
- smp_ready held 0 for 10 cycles while 6 beats are offered → tready falls after 4 beats (FIFO full); smp_data stays stable; on release, all 12 samples arrive in order with no loss.
- Assert s_axis_aresetn low mid-vector → all outputs 0 immediately; after release, a new start/stream of 2 samples completes cleanly.

Source files
------------

// File: rtl/svm_axis_pkg.sv
// rtl/svm_axis_pkg.sv - shared widths, FSM states and FIFO beat record for the sample unpacker
package svm_axis_pkg;

    localparam int WIDTH                = 16;
    localparam int C_S_AXIS_TDATA_WIDTH = 2 * WIDTH;
    localparam int LEN_W                = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } unpk_state_e;

    typedef struct packed {
        logic [C_S_AXIS_TDATA_WIDTH-1:0] data;
        logic                            hi_ok;
        logic                            last;
    } axis_beat_t;

endpackage

// File: rtl/svm_axis_sample_unpacker_if.sv
// rtl/svm_axis_sample_unpacker_if.sv - beat stream in, sample stream out
interface svm_axis_sample_unpacker_if;
    import svm_axis_pkg::*;

    logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata;
    logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb;
    logic                              s_axis_tlast;
    logic                              s_axis_tvalid;
    logic                              s_axis_tready;
    logic [WIDTH-1:0]                  smp_data;
    logic                              smp_valid;
    logic                              smp_ready;
    logic                              smp_last;

    modport slave (
        input  s_axis_tdata, s_axis_tstrb, s_axis_tlast, s_axis_tvalid, smp_ready,
        output s_axis_tready, smp_data, smp_valid, smp_last
    );

    modport master (
        output s_axis_tdata, s_axis_tstrb, s_axis_tlast, s_axis_tvalid, smp_ready,
        input  s_axis_tready, smp_data, smp_valid, smp_last
    );

endinterface

// File: rtl/svm_axis_beat_fifo.sv
// rtl/svm_axis_beat_fifo.sv - synchronous beat FIFO with flush, head read straight from storage
module svm_axis_beat_fifo
    import svm_axis_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  axis_beat_t wdata,
    output logic       full,
    output logic       empty,
    output axis_beat_t head
);

    localparam int AW = $clog2(DEPTH);

    axis_beat_t    mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/svm_axis_sample_unpacker.sv
// rtl/svm_axis_sample_unpacker.sv - splits 32-bit stream beats into 16-bit samples and polices vector length
module svm_axis_sample_unpacker
    import svm_axis_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      s_axis_aclk,
    input  logic                      s_axis_aresetn,
    svm_axis_sample_unpacker_if.slave axis,
    input  logic                      start,
    input  logic [LEN_W-1:0]          num_samples,
    output logic                      busy,
    output logic                      done,
    output logic                      len_err
);

    unpk_state_e      state;
    logic [LEN_W-1:0] exp_cnt;
    logic [LEN_W-1:0] smp_cnt;
    logic             sel;
    logic             tlast_seen;

    axis_beat_t       push_beat;
    axis_beat_t       head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             flush;

    logic             beat_acc;
    logic             smp_hs;
    logic             final_half;
    logic             cnt_hit;
    logic             tlast_acc;
    logic             end_hs;
    logic             clean_end;

    assign axis.s_axis_tready = (state == RUN && !fifo_full) || (state == FLUSH);
    assign beat_acc           = axis.s_axis_tvalid && axis.s_axis_tready;
    assign push               = beat_acc && (state == RUN);

    // Only the upper strobe pair matters; the low half is always delivered.
    assign push_beat.data  = axis.s_axis_tdata;
    assign push_beat.hi_ok = ((axis.s_axis_tstrb | 4'b0011) == 4'b1111);
    assign push_beat.last  = axis.s_axis_tlast;

    assign axis.smp_valid = (state == RUN) && !fifo_empty;
    assign smp_hs         = axis.smp_valid && axis.smp_ready;
    assign final_half     = head.last && (sel || !head.hi_ok);
    assign cnt_hit        = (smp_cnt == exp_cnt - LEN_W'(1));
    assign axis.smp_last  = axis.smp_valid && (cnt_hit || final_half);
    assign axis.smp_data  = !axis.smp_valid ? '0 :
                            sel ? head.data[2*WIDTH-1:WIDTH] : head.data[WIDTH-1:0];

    assign end_hs    = smp_hs && axis.smp_last;
    assign clean_end = cnt_hit && final_half;
    // A tlast beat arriving on the same edge as a long-stream end still counts as seen.
    assign tlast_acc = tlast_seen || (push && axis.s_axis_tlast);
    assign pop       = smp_hs && (sel || !head.hi_ok);
    assign flush     = end_hs && !clean_end;
    assign busy      = (state != IDLE);

    svm_axis_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (s_axis_aclk),
        .rst_n (s_axis_aresetn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_beat),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state      <= IDLE;
            exp_cnt    <= '0;
            smp_cnt    <= '0;
            sel        <= 1'b0;
            tlast_seen <= 1'b0;
            done       <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_err    <= 1'b0;
                        smp_cnt    <= '0;
                        sel        <= 1'b0;
                        tlast_seen <= 1'b0;
                        exp_cnt    <= num_samples;
                        if (num_samples == '0) done  <= 1'b1;
                        else                   state <= RUN;
                    end
                end
                RUN: begin
                    if (push && axis.s_axis_tlast) tlast_seen <= 1'b1;
                    if (smp_hs) begin
                        smp_cnt <= smp_cnt + LEN_W'(1);
                        sel     <= !sel && head.hi_ok;
                    end
                    if (end_hs) begin
                        sel <= 1'b0;
                        if (!clean_end) len_err <= 1'b1;
                        // Long stream with its tlast still upstream: drain until it passes.
                        if (!clean_end && cnt_hit && !tlast_acc) begin
                            state <= FLUSH;
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (beat_acc && axis.s_axis_tlast) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
